// File: rtl/fpdiv_ctrl.sv
// Goldschmidt significand divider sequencer: initial pass, ITERS refinements,
// Moore-decoded multiplier selects and A/B/C register enables.
module fpdiv_ctrl #(
   parameter int ITERS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       sel_mux2,
   output logic [1:0] sel_mux4,
   output logic       en_a,
   output logic       en_b,
   output logic       en_c
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_N0,
      S_D0,
      S_NI,
      S_DI,
      S_DONE
   } state_t;

   localparam logic [2:0] LAST = 3'(ITERS - 1);

   state_t     state, state_d;
   logic [2:0] cnt, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_N0;
               cnt_d   = '0;
            end
         end
         S_N0: state_d = S_D0;
         S_D0: state_d = S_NI;
         S_NI: state_d = (cnt == LAST) ? S_DONE : S_DI;
         S_DI: begin
            state_d = S_NI;
            cnt_d   = cnt + 3'd1;
         end
         S_DONE: begin
            if (start) begin
               state_d = S_N0;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Each busy state loads either A alone or the B/C pair, never both.
   always_comb begin
      sel_mux2 = 1'b0;
      sel_mux4 = 2'b00;
      en_a     = 1'b0;
      en_b     = 1'b0;
      en_c     = 1'b0;
      unique case (state)
         S_N0: begin
            en_a = 1'b1;
         end
         S_D0: begin
            sel_mux4 = 2'b01;
            en_b     = 1'b1;
            en_c     = 1'b1;
         end
         S_NI: begin
            sel_mux2 = 1'b1;
            sel_mux4 = 2'b10;
            en_a     = 1'b1;
         end
         S_DI: begin
            sel_mux2 = 1'b1;
            sel_mux4 = 2'b11;
            en_b     = 1'b1;
            en_c     = 1'b1;
         end
         default: ;
      endcase
   end

   assign ready = (state == S_IDLE) || (state == S_DONE);
   assign busy  = !ready;
   assign done  = (state == S_DONE);

endmodule
